// File: rtl/reg_bank_32x32.sv
// Integer register file storage: 32 x 32-bit registers, one synchronous write port,
// two combinational read ports and a flat snapshot bus. Optional macro WRITE_BYPASS_EN.
module reg_bank_32x32 (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [4:0]    wr_addr,
  input  logic [31:0]   wr_data,
  input  logic [4:0]    rs1_addr,
  input  logic [4:0]    rs2_addr,
  output logic [31:0]   rs1_data,
  output logic [31:0]   rs2_data,
  output logic [1023:0] regs_flat,
  output logic [15:0]   wr_count
);

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned CNT_WIDTH  = 16;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic                  wr_accept;

  assign wr_accept = wr_en && (wr_addr != ADDR_WIDTH'(0));

  // Register array; entry 0 is never written so it only ever holds its reset value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_accept) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Saturating count of accepted writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_count <= '0;
    end else if (wr_accept && (wr_count != {CNT_WIDTH{1'b1}})) begin
      wr_count <= wr_count + CNT_WIDTH'(1);
    end
  end

  // Snapshot bus; slice 0 is forced to zero so x0 never depends on flop contents.
  always_comb begin
    regs_flat = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      regs_flat[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end
  end

  // Read ports: 32:1 selects, with optional same-cycle forwarding of the write data.
  always_comb begin
    rs1_data = (rs1_addr == ADDR_WIDTH'(0)) ? DATA_WIDTH'(0) : regs_q[rs1_addr];
    rs2_data = (rs2_addr == ADDR_WIDTH'(0)) ? DATA_WIDTH'(0) : regs_q[rs2_addr];
`ifdef WRITE_BYPASS_EN
    if (!reset && wr_accept && (rs1_addr == wr_addr)) begin
      rs1_data = wr_data;
    end
    if (!reset && wr_accept && (rs2_addr == wr_addr)) begin
      rs2_data = wr_data;
    end
`else
    // Bypass not built: reads always return the stored value.
`endif
  end

endmodule

// File: tb/tb_reg_bank_32x32.sv
// Self-checking bench for reg_bank_32x32 against an array-based reference model.
`timescale 1ns/1ps
module tb_reg_bank_32x32;

  logic          clk;
  logic          reset;
  logic          wr_en;
  logic [4:0]    wr_addr;
  logic [31:0]   wr_data;
  logic [4:0]    rs1_addr;
  logic [4:0]    rs2_addr;
  logic [31:0]   rs1_data;
  logic [31:0]   rs2_data;
  logic [1023:0] regs_flat;
  logic [15:0]   wr_count;

  int unsigned   passed;
  int unsigned   total;
  logic [31:0]   mem [32];
  int unsigned   cnt;
  logic [31:0]   last_x1;

  reg_bank_32x32 dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .regs_flat (regs_flat),
    .wr_count  (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Expected read value this cycle, including forwarding when the bypass is built.
  function automatic logic [31:0] model_read(input logic [4:0] a);
    logic [31:0] v;
    v = (a == 5'd0) ? 32'h0 : mem[a];
`ifdef WRITE_BYPASS_EN
    if (!reset && wr_en && wr_addr != 5'd0 && a == wr_addr) v = wr_data;
`endif
    return v;
  endfunction

  function automatic logic [1023:0] model_flat();
    logic [1023:0] f;
    f = '0;
    for (int i = 1; i < 32; i++) f[i*32 +: 32] = mem[i];
    return f;
  endfunction

  // Apply the current inputs to the model, then advance one clock edge.
  task automatic tick();
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
      cnt = 0;
    end else if (wr_en && wr_addr != 5'd0) begin
      mem[wr_addr] = wr_data;
      if (cnt < 32'hFFFF) cnt = cnt + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".rs1"},  1024'(rs1_data),  1024'(model_read(rs1_addr)));
    chk({tag, ".rs2"},  1024'(rs2_data),  1024'(model_read(rs2_addr)));
    chk({tag, ".flat"}, regs_flat,        model_flat());
    chk({tag, ".cnt"},  1024'(wr_count),  1024'(cnt[15:0]));
  endtask

  initial begin
    passed = 0; total = 0; cnt = 0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rs1_addr = '0; rs2_addr = '0;
    #2;
    tick();
    reset = 1'b0;
    chk_all("reset_init");

    // Preload x5 then reset
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h1234; rs1_addr = 5'd5;
    tick();
    wr_en = 1'b0;
    chk("preload_x5", 1024'(rs1_data), 1024'(32'h1234));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_rs1", 1024'(rs1_data), 1024'(32'h0));
    chk("reset_flat", regs_flat, 1024'(0));
    chk("reset_cnt", 1024'(wr_count), 1024'(16'h0));

    // Write x7 and read back on both ports
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF;
    tick();
    wr_en = 1'b0; rs1_addr = 5'd7; rs2_addr = 5'd7;
    #1;
    chk("x7_rs1", 1024'(rs1_data), 1024'(32'hDEADBEEF));
    chk("x7_rs2", 1024'(rs2_data), 1024'(32'hDEADBEEF));
    chk("x7_cnt", 1024'(wr_count), 1024'(16'd1));

    // Write to x0 is discarded
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; rs1_addr = 5'd0;
    tick();
    wr_en = 1'b0;
    chk("x0_rs1", 1024'(rs1_data), 1024'(32'h0));
    chk("x0_flat", 1024'(regs_flat[31:0]), 1024'(32'h0));
    chk("x0_cnt", 1024'(wr_count), 1024'(16'd1));

    // Same-cycle write/read of x3
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5A5A5A5; rs2_addr = 5'd3;
    #1;
`ifdef WRITE_BYPASS_EN
    chk("x3_same", 1024'(rs2_data), 1024'(32'hA5A5A5A5));
`else
    chk("x3_same", 1024'(rs2_data), 1024'(32'h0));
`endif
    tick();
    wr_en = 1'b0;
    chk("x3_next", 1024'(rs2_data), 1024'(32'hA5A5A5A5));

    // Reset wins over simultaneous write
    reset = 1'b1; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55; rs1_addr = 5'd9;
    #1;
    chk("rst_wr_same", 1024'(rs1_data), 1024'(model_read(5'd9)));
    tick();
    reset = 1'b0; wr_en = 1'b0;
    chk("rst_wr_x9", 1024'(rs1_data), 1024'(32'h0));
    chk("rst_wr_cnt", 1024'(wr_count), 1024'(16'h0));

    // Randomized traffic, checked before each edge (exposes forwarding) and after
    for (int n = 0; n < 400; n++) begin
      reset    = ($urandom_range(0, 39) == 0);
      wr_en    = ($urandom_range(0, 3) != 0);
      wr_addr  = 5'($urandom_range(0, 31));
      wr_data  = $urandom;
      rs1_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      rs2_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      #1;
      chk_all("rand");
      tick();
    end
    reset = 1'b0; wr_en = 1'b0;
    #1;
    chk_all("rand_end");

    // Saturation: 65537 writes to x1
    wr_en = 1'b1; wr_addr = 5'd1; rs1_addr = 5'd1; rs2_addr = 5'd2;
    last_x1 = 32'h0;
    for (int n = 0; n < 65537; n++) begin
      wr_data = 32'(n) ^ 32'h5A000000;
      last_x1 = wr_data;
      tick();
    end
    wr_en = 1'b0;
    #1;
    chk("sat_cnt", 1024'(wr_count), 1024'(16'hFFFF));
    chk("sat_x1", 1024'(rs1_data), 1024'(last_x1));
    chk_all("sat_model");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
